fc_mem_writer: RTL and testbench
================================

# fc_mem_writer

Write-back engine for the fully-connected datapath. It captures a packed vector of 16-bit fixed-point nodes, such as an FC layer's output nodes, on a start pulse. It then serializes the vector into `FCmemory` one word per cycle, starting at a programmable base address. It drives the memory's single-word write port, so a layer's results can be stored and later read back as wide input rows.

## Interface

Parameters:
- `NUM_WORDS`, default 84: capacity of the packed input vector, in 16-bit words.
- `ADDR_W`, default 14: memory address width.
- `DATA_W`, default 16: word width.
- `LEN_W`, default `$clog2(NUM_WORDS+1)`: width of the runtime length input.

Ports:
- `clk`  in  1: single clock; all logic samples on the rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `start`  in  1: one-cycle request; honoured only in IDLE.
- `base_addr`  in  ADDR_W: first write address; sampled with `start`.
- `len`  in  LEN_W: number of words to write; sampled with `start`.
- `words_in`  in  NUM_WORDS*DATA_W: packed vector; word i is `words_in[i*DATA_W +: DATA_W]`; sampled with `start`.
- `busy`  out  1: high in WRITE and DONE.
- `done`  out  1: one-cycle completion pulse.
- `mem_address`  out  ADDR_W: connects to `FCmemory.address`.
- `mem_data_in`  out  DATA_W: connects to `FCmemory.data_in`.
- `mem_write_enable`  out  1: connects to `FCmemory.write_enable`.
- `mem_read_enable`  out  1: connects to `FCmemory.read_enable`; held 0 at all times.

## Operation

FSM states:
- IDLE
  - If `start` = 1: capture `base_addr`, `len` and `words_in` into internal registers and clear index `idx`.
  - A captured `len` of 0 goes to DONE; otherwise go to WRITE.
- WRITE
  - Each cycle drives `mem_address = base + idx`, `mem_data_in = word[idx]` and `mem_write_enable = 1`, then increments `idx`.
  - After the write with `idx = len-1`, go to DONE.
- DONE
  - `done` = 1 for exactly one cycle, then go to IDLE.

Rules:
- `len` > NUM_WORDS is clamped to NUM_WORDS at capture.
- Address arithmetic is modulo 2^ADDR_W. `base + idx` past 2^ADDR_W-1 wraps to 0 and raises no error.
- The captured copy is what gets written. `words_in` may change freely once `start` has been accepted.
- `start` in WRITE or DONE is ignored. It is not queued.
- `mem_data_in` and `mem_address` hold their last value when not writing. Only `mem_write_enable` qualifies them.

## Timing

- Reset values: state IDLE, `busy` = 0, `done` = 0, `mem_write_enable` = 0, `mem_read_enable` = 0, `mem_address` = 0, `mem_data_in` = 0, `idx` = 0.
- All outputs are registered.
- Let `start` be sampled at edge T0.
  - The first write is presented in cycle T0+1.
  - Write k is presented in cycle T0+1+k.
  - `done` is high in cycle T0+1+len.
  - `busy` is high from T0+1 through T0+1+len inclusive.
- `len` = 0: `done` is high in T0+1 and no write pulse occurs.
- Throughput: one word per cycle, no bubbles.
- Back-to-back commands: the earliest next accepted `start` is sampled in the cycle after `done`.
- `rst` during WRITE: at the next edge `mem_write_enable` goes to 0 and the FSM returns to IDLE. No further writes occur and no `done` is issued. Words already written remain in memory.

## Configuration

- `FC_WB_RELU_EN`
  - Defined: each word is passed through ReLU before writing. A word with MSB = 1 (negative, two's complement) is written as 0; other words are written unchanged. Latency is unchanged.
  - Undefined: words are written bit-exact.

## Test plan

- Reset, then start with base 0x0078, len 84 and word i = i+1 -> 84 consecutive write pulses at addresses 0x0078..0x00CB with data 1..84, `done` at T0+85, `busy` high for 85 cycles.
- Start with len 0 -> `done` at T0+1, `mem_write_enable` never asserted.
- Start with base 0x3FFE and len 4 -> writes at 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- `start` pulsed again mid-WRITE with different data -> ignored; the original sequence completes unchanged.
- Assert `rst` after the 10th write of a len-84 run -> no write pulses from the next edge on, no `done`, and all outputs at their reset values.
- With `FC_WB_RELU_EN` defined, write words 0x8001, 0x7FFF, 0x0000 -> data written is 0x0000, 0x7FFF, 0x0000. Without the macro, the same words are written unchanged.

Source files
------------

// File: rtl/fc_mem_writer.sv
// fc_mem_writer: captures a packed vector of fixed-point words on a start
// pulse and writes it into FCmemory one word per cycle, starting at a
// programmable base address.
// Optional build macro: FC_WB_RELU_EN. When defined, negative words are
// written as zero.
module fc_mem_writer #(
  parameter int NUM_WORDS = 84,
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 16,
  parameter int LEN_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [ADDR_W-1:0]           i_base_addr,
  input  logic [LEN_W-1:0]            i_len,
  input  logic [NUM_WORDS*DATA_W-1:0] i_words_in,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [ADDR_W-1:0]           o_mem_address,
  output logic [DATA_W-1:0]           o_mem_data_in,
  output logic                        o_mem_write_enable,
  output logic                        o_mem_read_enable
);

  localparam int VEC_W = NUM_WORDS * DATA_W;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(NUM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_stateNext;

  // Captured command. r_words is a shift register: its lowest word is always
  // the next word to be written, so no variable-index mux is needed.
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_idx;
  logic [VEC_W-1:0]    r_words;

  // Registered outputs.
  logic [ADDR_W-1:0]   r_memAddr;
  logic [DATA_W-1:0]   r_memData;
  logic                r_memWe;
  logic                r_busy;
  logic                r_done;

  // Next-state values produced by the combinational FSM process.
  logic [LEN_W-1:0]    w_lenNext;
  logic [LEN_W-1:0]    w_idxNext;
  logic [VEC_W-1:0]    w_wordsNext;
  logic [ADDR_W-1:0]   w_addrNext;
  logic [DATA_W-1:0]   w_dataNext;
  logic                w_weNext;
  logic                w_busyNext;
  logic                w_doneNext;

  logic [LEN_W-1:0]    w_capLen;
  logic [LEN_W-1:0]    w_lastIdx;

  // Word conditioning applied on the way to memory; latency is the same
  // whichever variant is built.
  function automatic logic [DATA_W-1:0] conditionWord(input logic [DATA_W-1:0] word);
`ifdef FC_WB_RELU_EN
    return word[DATA_W-1] ? '0 : word;
`else
    return word;
`endif
  endfunction

  // Requests longer than the vector are clamped to the vector capacity.
  assign w_capLen  = (i_len > MAX_LEN) ? MAX_LEN : i_len;
  assign w_lastIdx = r_len - LEN_W'(1);

  // Next-state and next-output logic; every output is computed one cycle
  // ahead so that it can be presented straight from a register.
  always_comb begin
    w_stateNext = r_state;
    w_lenNext   = r_len;
    w_idxNext   = r_idx;
    w_wordsNext = r_words;
    w_addrNext  = r_memAddr;
    w_dataNext  = r_memData;
    w_weNext    = 1'b0;
    w_busyNext  = 1'b0;
    w_doneNext  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_lenNext  = w_capLen;
          w_idxNext  = '0;
          w_busyNext = 1'b1;
          if (w_capLen == '0) begin
            w_stateNext = S_DONE;
            w_doneNext  = 1'b1;
          end else begin
            w_stateNext = S_WRITE;
            w_weNext    = 1'b1;
            w_addrNext  = i_base_addr;
            w_dataNext  = conditionWord(i_words_in[DATA_W-1:0]);
            w_wordsNext = i_words_in >> DATA_W;
          end
        end
      end

      S_WRITE: begin
        w_busyNext = 1'b1;
        if (r_idx == w_lastIdx) begin
          w_stateNext = S_DONE;
          w_doneNext  = 1'b1;
        end else begin
          w_weNext    = 1'b1;
          w_idxNext   = r_idx + LEN_W'(1);
          w_addrNext  = r_memAddr + ADDR_W'(1);
          w_dataNext  = conditionWord(r_words[DATA_W-1:0]);
          w_wordsNext = r_words >> DATA_W;
        end
      end

      S_DONE: begin
        w_stateNext = S_IDLE;
      end

      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; a reset mid-write
  // drops the remaining words and suppresses the done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_idx     <= '0;
      r_words   <= '0;
      r_memAddr <= '0;
      r_memData <= '0;
      r_memWe   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_len     <= w_lenNext;
      r_idx     <= w_idxNext;
      r_words   <= w_wordsNext;
      r_memAddr <= w_addrNext;
      r_memData <= w_dataNext;
      r_memWe   <= w_weNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
    end
  end

  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_mem_address      = r_memAddr;
  assign o_mem_data_in      = r_memData;
  assign o_mem_write_enable = r_memWe;
  assign o_mem_read_enable  = 1'b0;

endmodule

// File: tb/tb_fc_mem_writer.sv
// tb_fc_mem_writer: scoreboard bench for fc_mem_writer. Expected writes are
// queued when a command is driven and matched against every write pulse.
module tb_fc_mem_writer;

  localparam int NUM_WORDS = 84;
  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 16;
  localparam int LEN_W     = $clog2(NUM_WORDS + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic                        clk;
  logic                        rst;
  logic                        start;
  logic [ADDR_W-1:0]           baseAddr;
  logic [LEN_W-1:0]            len;
  logic [NUM_WORDS*DATA_W-1:0] wordsIn;
  logic                        busy;
  logic                        done;
  logic [ADDR_W-1:0]           memAddress;
  logic [DATA_W-1:0]           memDataIn;
  logic                        memWriteEnable;
  logic                        memReadEnable;

  logic [NUM_WORDS*DATA_W-1:0] stimWords;
  wr_t                         expQ[$];
  wr_t                         expItem;
  int                          checkCount = 0;
  int                          errorCount = 0;
  int                          writeCount = 0;

  fc_mem_writer #(
    .NUM_WORDS(NUM_WORDS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .LEN_W    (LEN_W)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_start           (start),
    .i_base_addr       (baseAddr),
    .i_len             (len),
    .i_words_in        (wordsIn),
    .o_busy            (busy),
    .o_done            (done),
    .o_mem_address     (memAddress),
    .o_mem_data_in     (memDataIn),
    .o_mem_write_enable(memWriteEnable),
    .o_mem_read_enable (memReadEnable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] modelWord(input logic [DATA_W-1:0] w);
`ifdef FC_WB_RELU_EN
    if (w[DATA_W-1]) return '0;
`endif
    return w;
  endfunction

  // Write-port monitor: every write pulse must match the head of the queue.
  always @(negedge clk) begin
    if (memWriteEnable === 1'b1) begin
      writeCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedWrite", 32'd1, 32'd0);
      end else begin
        expItem = expQ.pop_front();
        checkOutput("wrAddr", 32'(memAddress), 32'(expItem.addr));
        checkOutput("wrData", 32'(memDataIn), 32'(expItem.data));
      end
    end
  end

  // Drives one command at a falling edge and follows it cycle by cycle.
  // interfereAt names a cycle after T0 in which a competing start is pulsed.
  task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int lenReq,
                               input int interfereAt, input string tag);
    int lenEff;
    int writesBefore;
    lenEff = (lenReq > NUM_WORDS) ? NUM_WORDS : lenReq;
    for (int i = 0; i < lenEff; i++) begin
      expQ.push_back('{addr: ADDR_W'(32'(base) + i),
                       data: modelWord(stimWords[i*DATA_W +: DATA_W])});
    end
    writesBefore = writeCount;
    baseAddr = base;
    len      = LEN_W'(lenReq);
    wordsIn  = stimWords;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wordsIn  = ~stimWords;
    baseAddr = ~base;
    len      = '0;
    for (int c = 1; c <= lenEff + 1; c++) begin
      checkOutput({tag, "Busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "Done"}, 32'(done), 32'(c == lenEff + 1));
      checkOutput({tag, "RdEn"}, 32'(memReadEnable), 32'd0);
      if (c == interfereAt) begin
        start = 1'b1;
        len   = LEN_W'(5);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput({tag, "IdleBusy"}, 32'(busy), 32'd0);
    checkOutput({tag, "IdleDone"}, 32'(done), 32'd0);
    checkOutput({tag, "IdleWe"}, 32'(memWriteEnable), 32'd0);
    checkOutput({tag, "WriteCount"}, 32'(writeCount - writesBefore), 32'(lenEff));
    checkOutput({tag, "QueueLeft"}, 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  initial begin
    int writesBefore;
    rst      = 1'b1;
    start    = 1'b0;
    baseAddr = '0;
    len      = '0;
    wordsIn  = '0;
    stimWords = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstWe", 32'(memWriteEnable), 32'd0);
    checkOutput("rstRdEn", 32'(memReadEnable), 32'd0);
    checkOutput("rstAddr", 32'(memAddress), 32'd0);
    checkOutput("rstData", 32'(memDataIn), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] full-length run, base 0x0078");
    for (int i = 0; i < NUM_WORDS; i++) stimWords[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
    applyStimulus(14'h0078, 84, 0, "full");
    checkOutput("holdAddr", 32'(memAddress), 32'h00CB);
    checkOutput("holdData", 32'(memDataIn), 32'd84);

    $display("[TB] zero-length run");
    applyStimulus(14'h0100, 0, 0, "zero");
    checkOutput("zeroHoldAddr", 32'(memAddress), 32'h00CB);
    checkOutput("zeroHoldData", 32'(memDataIn), 32'd84);

    $display("[TB] address wrap with sign-sensitive words, start during DONE");
    stimWords = '0;
    stimWords[0*DATA_W +: DATA_W] = 16'h8001;
    stimWords[1*DATA_W +: DATA_W] = 16'h7FFF;
    stimWords[2*DATA_W +: DATA_W] = 16'h0000;
    stimWords[3*DATA_W +: DATA_W] = 16'hFFFF;
    applyStimulus(14'h3FFE, 4, 5, "wrap");

    $display("[TB] oversize length is clamped");
    for (int i = 0; i < NUM_WORDS; i++) stimWords[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    applyStimulus(14'h1000, 100, 0, "clamp");

    $display("[TB] start pulsed mid-write is ignored");
    for (int i = 0; i < NUM_WORDS; i++) stimWords[i*DATA_W +: DATA_W] = DATA_W'(i * 3 + 7);
    applyStimulus(14'h0200, 84, 5, "midStart");

    $display("[TB] reset after the 10th write");
    for (int i = 0; i < NUM_WORDS; i++) stimWords[i*DATA_W +: DATA_W] = DATA_W'(16'h4000 + i);
    for (int i = 0; i < NUM_WORDS; i++) begin
      expQ.push_back('{addr: ADDR_W'(32'h0300 + i), data: modelWord(stimWords[i*DATA_W +: DATA_W])});
    end
    writesBefore = writeCount;
    baseAddr = 14'h0300;
    len      = LEN_W'(84);
    wordsIn  = stimWords;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      checkOutput("rstRunBusy", 32'(busy), 32'd1);
      if (c < 10) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstWe", 32'(memWriteEnable), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstDone", 32'(done), 32'd0);
    checkOutput("midRstAddr", 32'(memAddress), 32'd0);
    checkOutput("midRstData", 32'(memDataIn), 32'd0);
    checkOutput("midRstWrites", 32'(writeCount - writesBefore), 32'd10);
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("postRstDone", 32'(done), 32'd0);
      checkOutput("postRstWe", 32'(memWriteEnable), 32'd0);
    end
    checkOutput("postRstWrites", 32'(writeCount - writesBefore), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
